// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive packet controller.
//   state_e       : controller FSM states (CSUM exists only with UART_PKT_CHECKSUM_EN)
//   ERR_*         : err_code encodings
//   SYNC_DEFAULT  : default start-of-frame marker
// Optional feature macro: UART_PKT_CHECKSUM_EN
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_PAY   = 3'd2,
`ifdef UART_PKT_CHECKSUM_EN
    ST_CSUM  = 3'd3,
`endif
    ST_DRAIN = 3'd4
  } state_e;

  localparam logic [1:0] ERR_OVERRUN = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_pkt_buffer.sv
// Single-packet payload store: MAX_LEN x 8 register file with independent
// write and read pointers. No flow control; the controller sequences it.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset (pointers only)
//   clr_i      : synchronous pointer clear
//   wr_en_i    : write wr_data_i at write pointer, then advance it
//   wr_data_i  : byte to store
//   rd_en_i    : advance read pointer
//   rd_data_o  : byte at read pointer (combinational)
//   wr_idx_o   : write pointer, zero-extended to 8 bits
//   rd_idx_o   : read pointer, zero-extended to 8 bits
module uart_pkt_buffer #(
  parameter int unsigned MAX_LEN = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       wr_en_i,
  input  logic [7:0] wr_data_i,
  input  logic       rd_en_i,
  output logic [7:0] rd_data_o,
  output logic [7:0] wr_idx_o,
  output logic [7:0] rd_idx_o
);

  localparam int unsigned PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [7:0]       mem [MAX_LEN];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en_i) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i && !clr_i) mem[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem[rd_ptr_q];
  assign wr_idx_o  = 8'(wr_ptr_q);
  assign rd_idx_o  = 8'(rd_ptr_q);

endmodule

// File: rtl/uart_rx_packet_ctrl.sv
// Frames the UART receive byte stream into packets:
//   SYNC, LEN, LEN payload bytes, [CSUM]
// buffers one packet, validates it, then drains it over a valid/ready stream.
//   clk        : clock, all logic on posedge
//   reset      : asynchronous active-low reset
//   rx_valid   : one-cycle pulse, rx_data holds a received byte
//   rx_data    : received byte
//   out_valid  : out_data valid
//   out_data   : payload byte
//   out_last   : final payload byte of the packet
//   out_ready  : consumer accepts when out_valid && out_ready
//   pkt_ok     : pulse, packet validated and drain begins
//   pkt_err    : pulse, frame/byte discarded; err_code qualifies
//   err_code   : last error (OVERRUN/LEN/CSUM/TIMEOUT)
//   pkt_count  : packets fully drained, wraps
// Optional feature macro: UART_PKT_CHECKSUM_EN (trailing checksum byte checked
// so that LEN + payload + CSUM == 0 mod 256). Undefined: frame ends after payload.
module uart_rx_packet_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4340
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        pkt_ok,
  output logic        pkt_err,
  output logic [1:0]  err_code,
  output logic [15:0] pkt_count
);

  localparam int unsigned TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  state_e        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pkt_ok_q, pkt_ok_d;
  logic          pkt_err_q, pkt_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [15:0]   pkt_count_q, pkt_count_d;
`ifdef UART_PKT_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  logic       buf_clr, buf_wr, buf_rd;
  logic [7:0] buf_rd_data, wr_idx, rd_idx;
  logic       drain_valid, drain_last, hs, timeout;

  uart_pkt_buffer #(
    .MAX_LEN (MAX_LEN)
  ) u_buf (
    .clk_i     (clk),
    .rst_ni    (reset),
    .clr_i     (buf_clr),
    .wr_en_i   (buf_wr),
    .wr_data_i (rx_data),
    .rd_en_i   (buf_rd),
    .rd_data_o (buf_rd_data),
    .wr_idx_o  (wr_idx),
    .rd_idx_o  (rd_idx)
  );

  assign drain_valid = (state_q == ST_DRAIN);
  assign drain_last  = drain_valid && (rd_idx == len_q - 8'd1);
  assign hs          = drain_valid && out_ready;
  // A byte arriving in the expiry cycle takes precedence over the timeout.
  assign timeout     = !rx_valid && (timer_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    timer_d     = rx_valid ? '0 : timer_q;
    pkt_ok_d    = 1'b0;
    pkt_err_d   = 1'b0;
    err_code_d  = err_code_q;
    pkt_count_d = pkt_count_q;
    buf_clr     = 1'b0;
    buf_wr      = 1'b0;
    buf_rd      = 1'b0;
`ifdef UART_PKT_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        buf_clr = 1'b1;
        if (rx_valid && rx_data == SYNC_BYTE) state_d = ST_LEN;
      end

      ST_LEN: begin
        if (rx_valid) begin
          if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
            pkt_err_d  = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = ST_IDLE;
          end else begin
            len_d   = rx_data;
`ifdef UART_PKT_CHECKSUM_EN
            csum_d  = rx_data;
`endif
            state_d = ST_PAY;
          end
        end else if (timeout) begin
          pkt_err_d  = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_PAY: begin
        if (rx_valid) begin
          buf_wr = 1'b1;
`ifdef UART_PKT_CHECKSUM_EN
          csum_d = csum_q + rx_data;
          if (wr_idx == len_q - 8'd1) state_d = ST_CSUM;
`else
          if (wr_idx == len_q - 8'd1) begin
            state_d  = ST_DRAIN;
            pkt_ok_d = 1'b1;
          end
`endif
        end else if (timeout) begin
          pkt_err_d  = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

`ifdef UART_PKT_CHECKSUM_EN
      ST_CSUM: begin
        if (rx_valid) begin
          if ((csum_q + rx_data) == 8'h00) begin
            state_d  = ST_DRAIN;
            pkt_ok_d = 1'b1;
          end else begin
            pkt_err_d  = 1'b1;
            err_code_d = ERR_CSUM;
            state_d    = ST_IDLE;
          end
        end else if (timeout) begin
          pkt_err_d  = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`endif

      ST_DRAIN: begin
        // Only one packet is buffered, so any byte arriving now is lost.
        if (rx_valid) begin
          pkt_err_d  = 1'b1;
          err_code_d = ERR_OVERRUN;
        end
        if (hs) begin
          buf_rd = 1'b1;
          if (drain_last) begin
            state_d     = ST_IDLE;
            pkt_count_d = pkt_count_q + 16'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      timer_q     <= '0;
      pkt_ok_q    <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= '0;
      pkt_count_q <= '0;
`ifdef UART_PKT_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      timer_q     <= timer_d;
      pkt_ok_q    <= pkt_ok_d;
      pkt_err_q   <= pkt_err_d;
      err_code_q  <= err_code_d;
      pkt_count_q <= pkt_count_d;
`ifdef UART_PKT_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign out_valid = drain_valid;
  assign out_data  = drain_valid ? buf_rd_data : '0;
  assign out_last  = drain_last;
  assign pkt_ok    = pkt_ok_q;
  assign pkt_err   = pkt_err_q;
  assign err_code  = err_code_q;
  assign pkt_count = pkt_count_q;

endmodule
